// File: rtl/trace_debugger_pkt_sched.sv
// Trace packet scheduler: qualifies samples, builds branch maps, emits packets.
// Optional macro TRDB_RESYNC_EN adds a SYNC every RESYNC_PERIOD samples.
module trace_debugger_pkt_sched #(
  parameter int MAP_LEN       = 31,
  parameter int RESYNC_PERIOD = 256
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         trace_enable_i,
  input  logic                         ivalid_i,
  input  logic                         iexception_i,
  input  logic                         interrupt_i,
  input  logic [4:0]                   cause_i,
  input  logic [2:0]                   priv_i,
  input  logic [31:0]                  iaddr_i,
  input  logic                         ibranch_i,
  input  logic                         ibranch_taken_i,
  output logic                         pkt_valid_o,
  input  logic                         pkt_ready_i,
  output logic [1:0]                   pkt_type_o,
  output logic [$clog2(MAP_LEN+1)-1:0] pkt_branches_o,
  output logic [MAP_LEN-1:0]           pkt_branch_map_o,
  output logic [31:0]                  pkt_addr_o,
  output logic [4:0]                   pkt_cause_o,
  output logic                         pkt_interrupt_o,
  output logic [2:0]                   pkt_priv_o,
  output logic                         overflow_o
);

  localparam int CW = $clog2(MAP_LEN+1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_TRACE
  } state_t;

  typedef enum logic [1:0] {
    P_FULL = 2'd0,
    P_SYNC = 2'd1,
    P_EXC  = 2'd2,
    P_STOP = 2'd3
  } ptype_t;

  state_t             state_q, state_d;
  logic [MAP_LEN-1:0] map_q, map_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [31:0]        last_addr_q;
  logic [2:0]         priv_q;

  logic               q;
  logic               busy;
  logic               due;
  logic               drop;
  logic               resync_hit;
  ptype_t             due_type;
  logic [31:0]        due_addr;
  logic [2:0]         due_priv;
  logic [4:0]         due_cause;
  logic               due_intr;
  logic [CW-1:0]      due_cnt;
  logic [MAP_LEN-1:0] due_map;
  logic [MAP_LEN-1:0] app_map;
  logic [CW-1:0]      app_cnt;

  assign q       = ivalid_i & trace_enable_i;
  assign busy    = pkt_valid_o & ~pkt_ready_i;
  assign app_map = map_q | (MAP_LEN'(ibranch_taken_i) << cnt_q);
  assign app_cnt = cnt_q + 1'b1;

`ifdef TRDB_RESYNC_EN
  localparam int RW = $clog2(RESYNC_PERIOD+1);
  logic [RW-1:0] rs_cnt_q, rs_cnt_d;

  assign resync_hit = (state_q == S_TRACE) && q &&
                      (rs_cnt_q == RW'(RESYNC_PERIOD-1));

  always_comb begin
    rs_cnt_d = rs_cnt_q;
    if (due && (due_type == P_SYNC || due_type == P_EXC))
      rs_cnt_d = '0;
    else if (state_q == S_TRACE && q)
      rs_cnt_d = rs_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rs_cnt_q <= '0;
    else         rs_cnt_q <= rs_cnt_d;
  end
`else
  assign resync_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    map_d     = map_q;
    cnt_d     = cnt_q;
    due       = 1'b0;
    due_type  = P_SYNC;
    due_addr  = iaddr_i;
    due_priv  = priv_i;
    due_cause = '0;
    due_intr  = 1'b0;
    due_cnt   = cnt_q;
    due_map   = map_q;
    unique case (state_q)
      S_IDLE: begin
        if (trace_enable_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!trace_enable_i) begin
          state_d = S_IDLE;
        end else if (q) begin
          due     = 1'b1;
          due_cnt = '0;
          due_map = '0;
          state_d = S_TRACE;
        end
      end
      S_TRACE: begin
        if (!trace_enable_i) begin
          due      = 1'b1;
          due_type = P_STOP;
          due_addr = last_addr_q;
          due_priv = priv_q;
          state_d  = S_IDLE;
        end else if (q) begin
          priority case (1'b1)
            iexception_i: begin
              due       = 1'b1;
              due_type  = P_EXC;
              due_cause = cause_i;
              due_intr  = interrupt_i;
            end
            (priv_i != priv_q), resync_hit: begin
              due = 1'b1;
            end
            ibranch_i: begin
              if (app_cnt == CW'(MAP_LEN)) begin
                due      = 1'b1;
                due_type = P_FULL;
                due_cnt  = app_cnt;
                due_map  = app_map;
              end else begin
                map_d = app_map;
                cnt_d = app_cnt;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A due packet always consumes the map, even when it cannot be stored
    if (due) begin
      map_d = '0;
      cnt_d = '0;
    end
    drop = due & busy;
    if (drop && due_type != P_STOP) state_d = S_WAIT;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      map_q       <= '0;
      cnt_q       <= '0;
      last_addr_q <= '0;
      priv_q      <= '0;
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      cnt_q   <= cnt_d;
      if (q) begin
        last_addr_q <= iaddr_i;
        priv_q      <= priv_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pkt_valid_o      <= 1'b0;
      pkt_type_o       <= '0;
      pkt_branches_o   <= '0;
      pkt_branch_map_o <= '0;
      pkt_addr_o       <= '0;
      pkt_cause_o      <= '0;
      pkt_interrupt_o  <= 1'b0;
      pkt_priv_o       <= '0;
    end else if (due && !busy) begin
      pkt_valid_o      <= 1'b1;
      pkt_type_o       <= due_type;
      pkt_branches_o   <= due_cnt;
      pkt_branch_map_o <= due_map;
      pkt_addr_o       <= due_addr;
      pkt_cause_o      <= due_cause;
      pkt_interrupt_o  <= due_intr;
      pkt_priv_o       <= due_priv;
    end else if (pkt_ready_i) begin
      pkt_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)             overflow_o <= 1'b0;
    else if (!trace_enable_i) overflow_o <= 1'b0;
    else if (drop)           overflow_o <= 1'b1;
  end

endmodule

// File: tb/tb_trace_debugger_pkt_sched.sv
// Bench for trace_debugger_pkt_sched: vector table, corner sequences and
// random stimulus against a queue-based packet model.
module tb_trace_debugger_pkt_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, iv, exc, intr, br, tk, rdy;
  logic [4:0]  cause;
  logic [2:0]  priv;
  logic [31:0] addr;
  logic        pv;
  logic [1:0]  pt;
  logic [4:0]  pn;
  logic [30:0] pm;
  logic [31:0] pa;
  logic [4:0]  pc;
  logic        pi;
  logic [2:0]  pp;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  trace_debugger_pkt_sched dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .trace_enable_i   (en),
    .ivalid_i         (iv),
    .iexception_i     (exc),
    .interrupt_i      (intr),
    .cause_i          (cause),
    .priv_i           (priv),
    .iaddr_i          (addr),
    .ibranch_i        (br),
    .ibranch_taken_i  (tk),
    .pkt_valid_o      (pv),
    .pkt_ready_i      (rdy),
    .pkt_type_o       (pt),
    .pkt_branches_o   (pn),
    .pkt_branch_map_o (pm),
    .pkt_addr_o       (pa),
    .pkt_cause_o      (pc),
    .pkt_interrupt_o  (pi),
    .pkt_priv_o       (pp),
    .overflow_o       (ovf)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 off, 1 awaiting sync, 2 tracing
  int          m_mode;
  bit          m_br[$];
  logic [31:0] m_last;
  logic [2:0]  m_priv;
  logic        m_ovf;
  logic        e_v;
  logic [1:0]  e_t;
  logic [4:0]  e_n;
  logic [30:0] e_m;
  logic [31:0] e_a;
  logic [4:0]  e_c;
  logic        e_i;
  logic [2:0]  e_p;

  task automatic model_reset();
    m_mode = 0; m_br.delete(); m_last = '0; m_priv = '0; m_ovf = 0;
    e_v = 0; e_t = 0; e_n = 0; e_m = 0; e_a = 0; e_c = 0; e_i = 0; e_p = 0;
  endtask

  task automatic model_step();
    bit q, due, busy;
    int nmode;
    logic [1:0] t; logic [4:0] n; logic [30:0] mp;
    logic [31:0] a; logic [4:0] c; logic ii; logic [2:0] p;
    q = iv & en; due = 0; nmode = m_mode;
    mp = '0;
    for (int i = 0; i < m_br.size(); i++) mp[i] = m_br[i];
    n = 5'(m_br.size());
    t = 2'd1; a = addr; p = priv; c = '0; ii = 0;
    if (m_mode == 0) begin
      if (en) nmode = 1;
    end else if (m_mode == 1) begin
      if (!en) nmode = 0;
      else if (q) begin due = 1; n = 0; mp = '0; nmode = 2; end
    end else begin
      if (!en) begin
        due = 1; t = 2'd3; a = m_last; p = m_priv; m_br.delete(); nmode = 0;
      end else if (q) begin
        if (exc) begin
          due = 1; t = 2'd2; c = cause; ii = intr; m_br.delete();
        end else if (priv != m_priv) begin
          due = 1; m_br.delete();
        end else if (br) begin
          m_br.push_back(tk);
          if (m_br.size() == 31) begin
            due = 1; t = 2'd0; n = 5'd31; mp[30] = tk; m_br.delete();
          end
        end
      end
    end
    busy = e_v && !rdy;
    if (due && busy) begin
      m_ovf = 1;
      if (t != 2'd3) nmode = 1;
    end else if (due) begin
      e_v = 1; e_t = t; e_n = n; e_m = mp; e_a = a; e_c = c; e_i = ii; e_p = p;
    end else if (rdy) begin
      e_v = 0;
    end
    if (!en) m_ovf = 0;
    if (q) begin m_last = addr; m_priv = priv; end
    m_mode = nmode;
  endtask

  task automatic model_chk();
    chk("m_valid", 64'(pv), 64'(e_v));
    chk("m_ovf", 64'(ovf), 64'(m_ovf));
    if (e_v) begin
      chk("m_type", 64'(pt), 64'(e_t));
      chk("m_branches", 64'(pn), 64'(e_n));
      chk("m_map", 64'(pm), 64'(e_m));
      chk("m_addr", 64'(pa), 64'(e_a));
      chk("m_cause", 64'(pc), 64'(e_c));
      chk("m_intr", 64'(pi), 64'(e_i));
      chk("m_priv", 64'(pp), 64'(e_p));
    end
  endtask

  task automatic drive(logic e, logic v, logic x, logic ir, logic [4:0] cs,
                       logic [2:0] pr, logic [31:0] ad, logic b, logic k,
                       logic r);
    en = e; iv = v; exc = x; intr = ir; cause = cs;
    priv = pr; addr = ad; br = b; tk = k; rdy = r;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    model_chk();
  endtask

  typedef struct packed {
    logic        e, v, x, ir;
    logic [4:0]  cs;
    logic [2:0]  pr;
    logic [31:0] ad;
    logic        b, k, r;
    logic        ev;
    logic [1:0]  et;
    logic [4:0]  en_;
    logic [30:0] em;
    logic [31:0] ea;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{1,0,0,0,0,3,32'h0,0,0,1, 0,0,0,0,0};
    tbl[1] = '{1,1,0,0,0,3,32'h1C000080,1,1,1, 1,1,0,0,32'h1C000080};
    tbl[2] = '{1,1,0,0,0,3,32'h1C000084,1,1,1, 0,0,0,0,0};
    tbl[3] = '{1,1,0,0,0,3,32'h1C000088,1,0,1, 0,0,0,0,0};
    tbl[4] = '{1,1,0,0,0,3,32'h1C00008C,1,1,1, 0,0,0,0,0};
    tbl[5] = '{1,1,1,0,5,3,32'h1C000100,1,1,1, 1,2,3,5,32'h1C000100};
    tbl[6] = '{1,1,0,0,0,3,32'h1C000104,0,0,1, 0,0,0,0,0};
    tbl[7] = '{1,1,0,0,0,3,32'h1C000108,1,1,1, 0,0,0,0,0};
    tbl[8] = '{1,1,0,0,0,1,32'h1C00010C,0,0,1, 1,1,1,1,32'h1C00010C};

    drive(0,0,0,0,0,0,0,0,0,1);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_valid", 64'(pv), 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);
    chk("reset_addr", 64'(pa), 64'd0);

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].e, tbl[i].v, tbl[i].x, tbl[i].ir, tbl[i].cs, tbl[i].pr,
            tbl[i].ad, tbl[i].b, tbl[i].k, tbl[i].r);
      step();
      chk($sformatf("t%0d_valid", i), 64'(pv), 64'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("t%0d_type", i), 64'(pt), 64'(tbl[i].et));
        chk($sformatf("t%0d_br", i), 64'(pn), 64'(tbl[i].en_));
        chk($sformatf("t%0d_map", i), 64'(pm), 64'(tbl[i].em));
        chk($sformatf("t%0d_addr", i), 64'(pa), 64'(tbl[i].ea));
      end
    end

    for (int i = 0; i < 31; i++) begin
      drive(1,1,0,0,0,1,32'h1C001000 + 32'(4*i),1,(i % 2 == 0),1);
      step();
      if (i < 30) chk("full_pre_valid", 64'(pv), 64'd0);
    end
    chk("full_valid", 64'(pv), 64'd1);
    chk("full_type", 64'(pt), 64'd0);
    chk("full_br", 64'(pn), 64'd31);
    chk("full_map", 64'(pm), 64'h55555555);
    chk("full_addr", 64'(pa), 64'h1C001078);

    drive(1,0,0,0,0,1,0,0,0,1);
    step();
    drive(1,1,0,0,0,3,32'h1C002000,0,0,0);
    step();
    chk("ovf_sync_type", 64'(pt), 64'd1);
    chk("ovf_sync_addr", 64'(pa), 64'h1C002000);
    drive(1,1,1,0,7,3,32'h1C002004,0,0,0);
    step();
    chk("ovf_hold_valid", 64'(pv), 64'd1);
    chk("ovf_hold_type", 64'(pt), 64'd1);
    chk("ovf_hold_addr", 64'(pa), 64'h1C002000);
    chk("ovf_set", 64'(ovf), 64'd1);
    drive(1,0,0,0,0,3,0,0,0,1);
    step();
    chk("ovf_drain", 64'(pv), 64'd0);
    drive(1,1,0,0,0,3,32'h1C002008,1,1,1);
    step();
    chk("resync_type", 64'(pt), 64'd1);
    chk("resync_br", 64'(pn), 64'd0);
    chk("resync_addr", 64'(pa), 64'h1C002008);
    chk("ovf_sticky", 64'(ovf), 64'd1);

    drive(1,1,0,0,0,3,32'h1C0001FC,1,1,1);
    step();
    drive(1,1,0,0,0,3,32'h1C000200,1,0,1);
    step();
    drive(0,1,0,0,0,3,32'h1C000300,1,1,1);
    step();
    chk("stop_valid", 64'(pv), 64'd1);
    chk("stop_type", 64'(pt), 64'd3);
    chk("stop_br", 64'(pn), 64'd2);
    chk("stop_map", 64'(pm), 64'd1);
    chk("stop_addr", 64'(pa), 64'h1C000200);
    chk("stop_ovf_clr", 64'(ovf), 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(0,1,0,0,0,3,32'h1C000304,1,1,1);
      step();
      chk("idle_quiet", 64'(pv), 64'd0);
    end

    drive(1,0,0,0,0,3,0,0,0,0);
    step();
    drive(1,1,0,0,0,3,32'h1C000400,0,0,0);
    step();
    chk("prerst_valid", 64'(pv), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 64'(pv), 64'd0);
    chk("arst_addr", 64'(pa), 64'd0);
    chk("arst_type", 64'(pt), 64'd0);
    chk("arst_priv", 64'(pp), 64'd0);
    chk("arst_ovf", 64'(ovf), 64'd0);
    drive(0,0,0,0,0,0,0,0,0,1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    begin
      logic e = 1'b1;
      logic [2:0] rp = 3'd3;
      logic [31:0] ra = 32'h1C010000;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(99) == 0) e = ~e;
        if ($urandom_range(49) == 0) rp = 3'($urandom_range(3));
        ra = ra + 32'd4;
        drive(e, ($urandom_range(9) < 8), ($urandom_range(49) == 0),
              1'($urandom_range(1)), 5'($urandom_range(31)), rp, ra,
              ($urandom_range(9) < 6), 1'($urandom_range(1)),
              ($urandom_range(9) < 8));
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
